// File: rtl/stored_carry_pkg.sv
// Shared types and the bit-level full adder used by the stored-carry accumulator.
// A digit holds two equal-weight bits, s (bit 1) and c (bit 0).
package stored_carry_pkg;

    typedef logic [1:0] sc_digit_t;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } sc_acc_state_t;

    // Returns {carry, sum}.
    function automatic logic [1:0] fullAdd(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/stored_carry_resolve_chunk.sv
// Converts CHUNK stored-carry digits plus an incoming carry into CHUNK binary bits.
// This is a plain full-adder ripple across the chunk.
module stored_carry_resolve_chunk
    import stored_carry_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  sc_digit_t [CHUNK-1:0] digits,
    input  logic                  carryIn,
    output logic      [CHUNK-1:0] sumBits,
    output logic                  carryOut
);

    logic [CHUNK:0] ripple;

    assign ripple[0] = carryIn;

    for (genvar i = 0; i < CHUNK; i++) begin : gRipple
        assign {ripple[i+1], sumBits[i]} = fullAdd(digits[i][1], digits[i][0], ripple[i]);
    end

    assign carryOut = ripple[CHUNK];

endmodule

// File: rtl/stored_carry_accumulator.sv
// Streaming accumulator: operands are folded into a stored-carry register one CSA level per beat.
// The sum is then resolved CHUNK digits per cycle and held on a valid/ready output.
module stored_carry_accumulator
    import stored_carry_pkg::*;
#(
    parameter int W     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam int N    = W / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    if (W % CHUNK != 0) begin : gBadChunk
        $error("stored_carry_accumulator: W must be a multiple of CHUNK");
    end

    sc_acc_state_t         state;
    sc_acc_state_t         stateNext;
    sc_digit_t [W-1:0]     acc;
    sc_digit_t [W-1:0]     accCsa;
    logic      [IDXW-1:0]  idx;
    logic                  carry;

    logic [W-1:0]          sBits;
    logic [W-1:0]          cBits;
    logic [W-1:0]          csaSum;
    logic [W-2:0]          csaCarry;

    sc_digit_t [CHUNK-1:0] chunkDigits;
    logic      [CHUNK-1:0] chunkSum;
    logic                  chunkCarry;

    // One carry-save level: the top carry is never computed, which is the mod 2^W wrap.
    for (genvar i = 0; i < W; i++) begin : gSplit
        assign sBits[i] = acc[i][1];
        assign cBits[i] = acc[i][0];
    end

    assign csaSum   = sBits ^ cBits ^ in_data;
    assign csaCarry = (sBits[W-2:0] & cBits[W-2:0])
                    | (sBits[W-2:0] & in_data[W-2:0])
                    | (cBits[W-2:0] & in_data[W-2:0]);

    for (genvar i = 0; i < W; i++) begin : gCsa
        if (i == 0) begin : gLsb
            assign accCsa[i] = {csaSum[i], 1'b0};
        end else begin : gUpper
            assign accCsa[i] = {csaSum[i], csaCarry[i-1]};
        end
    end

    assign chunkDigits = acc[int'(idx) * CHUNK +: CHUNK];

    stored_carry_resolve_chunk #(
        .CHUNK (CHUNK)
    ) u_resolve (
        .digits   (chunkDigits),
        .carryIn  (carry),
        .sumBits  (chunkSum),
        .carryOut (chunkCarry)
    );

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) stateNext = RESOLVE;
            end
            RESOLVE: begin
                if (idx == LAST_IDX) stateNext = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) stateNext = ACCUM;
            end
            default: stateNext = ACCUM;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            acc      <= '0;
            out_data <= '0;
            idx      <= '0;
            carry    <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= accCsa;
                        if (in_last) begin
                            idx   <= '0;
                            carry <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    out_data[int'(idx) * CHUNK +: CHUNK] <= chunkSum;
                    carry                                <= chunkCarry;
                    idx                                  <= idx + 1'b1;
                end
                OUTPUT: begin
                    if (out_ready) acc <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stored_carry_accumulator.sv
// Self-checking bench: four accumulators (CHUNK = 4, 1, 2, 8) driven with directed,
// table-driven and random groups; expected sums come from plain integer addition.
module tb_stored_carry_accumulator;

    localparam int W = 8;

    typedef struct packed {
        logic [2:0]      nBeats;
        logic [3:0][7:0] beats;
        logic [7:0]      expected;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid  [4];
    logic         inReady  [4];
    logic [W-1:0] inData   [4];
    logic         inLast   [4];
    logic         outValid [4];
    logic         outReady [4];
    logic [W-1:0] outData  [4];

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    stored_carry_accumulator #(.W(W), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
        .in_last(inLast[0]), .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]));

    stored_carry_accumulator #(.W(W), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
        .in_last(inLast[1]), .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]));

    stored_carry_accumulator #(.W(W), .CHUNK(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]),
        .in_last(inLast[2]), .out_valid(outValid[2]), .out_ready(outReady[2]), .out_data(outData[2]));

    stored_carry_accumulator #(.W(W), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid[3]), .in_ready(inReady[3]), .in_data(inData[3]),
        .in_last(inLast[3]), .out_valid(outValid[3]), .out_ready(outReady[3]), .out_data(outData[3]));

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Cycles from the last-beat edge until out_valid is seen: W/CHUNK resolve cycles plus one.
    function automatic int latencyOf(input int k);
        case (k)
            0:       return W / 4 + 1;
            1:       return W / 1 + 1;
            2:       return W / 2 + 1;
            default: return W / 8 + 1;
        endcase
    endfunction

    function automatic logic [7:0] modelSum(input logic [7:0] beats[$]);
        int total = 0;
        foreach (beats[i]) total += int'(beats[i]);
        return 8'(total % 256);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid dropped.
    task automatic sendBeat(input int k, input logic [7:0] data, input logic last);
        int waited = 0;
        inValid[k] = 1'b1;
        inData[k]  = data;
        inLast[k]  = last;
        while (!inReady[k] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("dut%0d in_ready before beat", k), 32'(inReady[k]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        inValid[k] = 1'b0;
        inLast[k]  = 1'b0;
    endtask

    // Called at the negedge right after the last beat was accepted.
    task automatic waitResult(input int k, input logic [7:0] want, input string tag);
        int cycles = 1;
        while (!outValid[k] && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, " out_valid"}, 32'(outValid[k]), 32'd1);
        check({tag, " latency"},   32'(cycles),      32'(latencyOf(k)));
        check({tag, " out_data"},  32'(outData[k]),  32'(want));
    endtask

    task automatic runGroup(input int k, input logic [7:0] beats[$], input logic [7:0] want,
                            input string tag, input bit gaps);
        foreach (beats[i]) begin
            if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
            sendBeat(k, beats[i], i == beats.size() - 1);
        end
        waitResult(k, want, tag);
        @(negedge clk);
        check({tag, " out_valid drop"}, 32'(outValid[k]), 32'd0);
        check({tag, " in_ready back"},  32'(inReady[k]),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       vecs [6];
        logic [7:0] q[$];

        vecs[0] = '{3'd3, {8'h00, 8'h7F, 8'h25, 8'h10}, 8'hB4};
        vecs[1] = '{3'd2, {8'h00, 8'h00, 8'h02, 8'hFF}, 8'h01};
        vecs[2] = '{3'd1, {8'h00, 8'h00, 8'h00, 8'hA5}, 8'hA5};
        vecs[3] = '{3'd4, {8'h80, 8'h80, 8'h80, 8'h80}, 8'h00};
        vecs[4] = '{3'd2, {8'h00, 8'h00, 8'hF1, 8'h0F}, 8'h00};
        vecs[5] = '{3'd3, {8'h00, 8'hFF, 8'hFF, 8'hFF}, 8'hFD};

        for (int k = 0; k < 4; k++) begin
            inValid[k]  = 1'b0;
            inData[k]   = '0;
            inLast[k]   = 1'b0;
            outReady[k] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dut%0d reset in_ready", k),  32'(inReady[k]),  32'd1);
            check($sformatf("dut%0d reset out_valid", k), 32'(outValid[k]), 32'd0);
            check($sformatf("dut%0d reset out_data", k),  32'(outData[k]),  32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Table-driven groups on every chunk width.
        for (int k = 0; k < 4; k++) begin
            for (int v = 0; v < 6; v++) begin
                q.delete();
                for (int b = 0; b < int'(vecs[v].nBeats); b++) q.push_back(vecs[v].beats[b]);
                runGroup(k, q, vecs[v].expected, $sformatf("dut%0d vec%0d", k, v), 1'b0);
            end
        end

        // Result held while downstream stalls for five cycles.
        outReady[0] = 1'b0;
        sendBeat(0, 8'h12, 1'b0);
        sendBeat(0, 8'h34, 1'b1);
        waitResult(0, 8'h46, "hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d out_valid", i), 32'(outValid[0]), 32'd1);
            check($sformatf("hold%0d out_data", i),  32'(outData[0]),  32'h46);
            check($sformatf("hold%0d in_ready", i),  32'(inReady[0]),  32'd0);
        end
        outReady[0] = 1'b1;
        @(negedge clk);
        check("hold release out_valid", 32'(outValid[0]), 32'd0);
        q = '{8'h01};
        runGroup(0, q, 8'h01, "after hold", 1'b0);

        // A beat offered during RESOLVE must wait and land in the following group.
        sendBeat(0, 8'h20, 1'b1);
        inValid[0] = 1'b1;
        inData[0]  = 8'h55;
        inLast[0]  = 1'b0;
        waitResult(0, 8'h20, "stall");
        @(negedge clk);
        check("stall in_ready after output", 32'(inReady[0]), 32'd1);
        @(negedge clk);
        sendBeat(0, 8'h0A, 1'b1);
        waitResult(0, 8'h5F, "stall next");
        @(negedge clk);

        // Reset in the middle of RESOLVE drops the pending result and the partial sum.
        sendBeat(0, 8'h40, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset in_ready",  32'(inReady[0]),  32'd1);
        check("mid reset out_valid", 32'(outValid[0]), 32'd0);
        check("mid reset out_data",  32'(outData[0]),  32'd0);
        q = '{8'h03};
        runGroup(0, q, 8'h03, "after reset", 1'b0);

        // Random groups against the integer reference on every chunk width.
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 8; g++) begin
                int n = $urandom_range(1, 5);
                q.delete();
                for (int b = 0; b < n; b++) q.push_back(8'($urandom_range(0, 255)));
                runGroup(k, q, modelSum(q), $sformatf("dut%0d rnd%0d", k, g), 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
